pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the datapath payload (alu_result, store data, target, imm, ...).
REQ-002 SHALL have parameter CTRL_W, default 8, width of the control payload (RegWrite, MemRead, MemWrite, ...).
REQ-003 SHALL have parameter SKID, default 1; 1 selects a two-entry skid buffer with registered in_ready, 0 selects a single entry.
REQ-004 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 flush  in  1  discard all held entries (hazard/branch kill).
REQ-007 stall  in  1  hold the output entry regardless of out_ready.
REQ-008 in_valid  in  1  upstream entry present; in_ready  out  1  stage accepts this cycle.
REQ-009 in_data  in  DATA_W; in_ctrl  in  CTRL_W  upstream payload.
REQ-010 out_valid  out  1; out_ready  in  1  downstream accept.
REQ-011 out_data  out  DATA_W; out_ctrl  out  CTRL_W  head-entry payload.
REQ-012 occupancy  out  2  held entry count, 0..2.
REQ-013 bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

Function
REQ-014 Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready & ~stall.
REQ-015 Latency: an accepted entry SHALL appear on out_* the next cycle when the stage was empty or drained in the same cycle.
REQ-016 States: EMPTY (occ 0), ONE (main full), TWO (main+skid full; SKID=1 only).
REQ-017 EMPTY: accept -> ONE; else stay.
REQ-018 ONE: accept & drain -> ONE, main loads the new entry; accept & ~drain -> TWO, skid loads the new entry (SKID=1); ~accept & drain -> EMPTY; else hold.
REQ-019 TWO: drain -> ONE, skid moves to main; no accept is possible.
REQ-020 SKID=1: in_ready SHALL be a registered signal equal to (state != TWO), with no combinational path from out_ready or stall.
REQ-021 SKID=0: in_ready SHALL equal (state==EMPTY) | drain (combinational), and the TWO state SHALL not exist.
REQ-022 Output ordering SHALL be FIFO; no entry is duplicated or lost except by flush.
REQ-023 out_data and out_ctrl SHALL reflect main only; when out_valid=0 they SHALL be 0.
REQ-024 flush SHALL next-cycle clear both entries to 0 (data and ctrl), set state to EMPTY, and discard any same-cycle accept; in_ready follows REQ-020/021 unchanged.
REQ-025 Priority SHALL be rst > flush > stall > normal operation.
REQ-026 stall=1 SHALL hold main and skid; accepts into free slots SHALL still occur.
REQ-027 bubble_cnt SHALL increment by 1 each cycle out_valid=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-028 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-029 On rst sampled high at a clk edge, state SHALL be EMPTY, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, bubble_cnt=0; with SKID=1, in_ready=1 from the first cycle after reset.
REQ-030 A rst asserted mid-operation SHALL drop all held entries with no partial drain.
REQ-031 Once rst deasserts, the first accept SHALL be honoured in the same cycle.

Verification
REQ-032 Streaming: SKID=1, in_valid=1 continuously with data 1,2,3...; out_ready=1 -> out_data 1,2,3... one cycle later, one entry per cycle, occupancy=1.
REQ-033 Backpressure: push A=0xA5, B=0x5A; out_ready=0 for 3 cycles -> occupancy=2, in_ready=0 the cycle after B; on release the order is A then B, and in_ready=1 again the cycle after A drains.
REQ-034 Flush while TWO with a simultaneous in_valid (C=0x33) -> next cycle out_valid=0, occupancy=0, out_data=0; C never appears.
REQ-035 Stall: main=0x11 held, stall=1, out_ready=1 for 2 cycles -> out_data stays 0x11 with no drain; the drain occurs on the first cycle after stall drops.
REQ-036 Counter: CNT_W=2, idle for 5 cycles after reset -> bubble_cnt 1,2,3,3,3.
REQ-037 SKID=0: out_ready toggling 1,0,1 with in_valid=1 -> in_ready mirrors the combinational rule, occupancy never exceeds 1, and no loss occurs.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with an optional two-entry skid buffer, flush/stall control,
// occupancy reporting and a saturating output-bubble counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] main_data, main_data_next, skid_data, skid_data_next;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_next, skid_ctrl, skid_ctrl_next;
    logic              accept, drain;

    assign out_valid = (state != EMPTY);
    assign drain     = out_valid & out_ready & ~stall;
    assign accept    = in_valid & in_ready;
    assign occupancy = state;
    assign out_data  = out_valid ? main_data : '0;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    // With the skid slot, in_ready comes straight from a flop so upstream never
    // sees a path from out_ready or stall.
    generate
        if (SKID != 0) begin : g_skid_ready
            logic ready_q;
            always_ff @(posedge clk) begin
                if (rst)
                    ready_q <= 1'b1;
                else
                    ready_q <= (state_next != TWO);
            end
            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = (state == EMPTY) | drain;
        end
    endgenerate

    always_comb begin
        state_next     = state;
        main_data_next = main_data;
        main_ctrl_next = main_ctrl;
        skid_data_next = skid_data;
        skid_ctrl_next = skid_ctrl;
        if (flush) begin
            state_next     = EMPTY;
            main_data_next = '0;
            main_ctrl_next = '0;
            skid_data_next = '0;
            skid_ctrl_next = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next     = ONE;
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                    end else if (accept && SKID != 0) begin
                        state_next     = TWO;
                        skid_data_next = in_data;
                        skid_ctrl_next = in_ctrl;
                    end else if (drain) begin
                        state_next     = EMPTY;
                        main_data_next = '0;
                        main_ctrl_next = '0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_next     = ONE;
                        main_data_next = skid_data;
                        main_ctrl_next = skid_ctrl;
                        skid_data_next = '0;
                        skid_ctrl_next = '0;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_next;
            main_data <= main_data_next;
            main_ctrl <= main_ctrl_next;
            skid_data <= skid_data_next;
            skid_ctrl <= skid_ctrl_next;
        end
    end

    // Bubble count ignores flush on purpose: it measures lost output slots.
    always_ff @(posedge clk) begin
        if (rst)
            bubble_cnt <= '0;
        else if (!out_valid && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: a SKID=1/CNT_W=2 stage and a SKID=0 stage, checked with immediate assertions.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    logic        sk_flush, sk_stall, sk_in_valid, sk_in_ready, sk_out_valid, sk_out_ready;
    logic [31:0] sk_in_data, sk_out_data;
    logic [7:0]  sk_in_ctrl, sk_out_ctrl;
    logic [1:0]  sk_occ;
    logic [1:0]  sk_bubble;

    logic        ns_flush, ns_stall, ns_in_valid, ns_in_ready, ns_out_valid, ns_out_ready;
    logic [31:0] ns_in_data, ns_out_data;
    logic [7:0]  ns_in_ctrl, ns_out_ctrl;
    logic [1:0]  ns_occ;
    logic [15:0] ns_bubble;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(2)) u_sk (
        .clk(clk), .rst(rst), .flush(sk_flush), .stall(sk_stall),
        .in_valid(sk_in_valid), .in_ready(sk_in_ready), .in_data(sk_in_data), .in_ctrl(sk_in_ctrl),
        .out_valid(sk_out_valid), .out_ready(sk_out_ready), .out_data(sk_out_data), .out_ctrl(sk_out_ctrl),
        .occupancy(sk_occ), .bubble_cnt(sk_bubble)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_ns (
        .clk(clk), .rst(rst), .flush(ns_flush), .stall(ns_stall),
        .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data), .in_ctrl(ns_in_ctrl),
        .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data), .out_ctrl(ns_out_ctrl),
        .occupancy(ns_occ), .bubble_cnt(ns_bubble)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control payload is the inverted low data byte so ctrl routing is checked too.
    task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic ordy,
                                 input logic stl, input logic fl);
        sk_in_valid  = vld;
        sk_in_data   = data;
        sk_in_ctrl   = ~data[7:0];
        sk_out_ready = ordy;
        sk_stall     = stl;
        sk_flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        ns_flush = 1'b0; ns_stall = 1'b0; ns_in_valid = 1'b0;
        ns_in_data = '0; ns_in_ctrl = '0; ns_out_ready = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_out_valid", {31'd0, sk_out_valid}, 32'd0);
        checkOutput("rst_out_data", sk_out_data, 32'd0);
        checkOutput("rst_out_ctrl", {24'd0, sk_out_ctrl}, 32'd0);
        checkOutput("rst_occ", {30'd0, sk_occ}, 32'd0);
        checkOutput("rst_bubble", {30'd0, sk_bubble}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, sk_in_ready}, 32'd1);
        checkOutput("rst_ns_occ", {30'd0, ns_occ}, 32'd0);

        $display("[TB] bubble counter saturation");
        rst = 1'b0;
        tick(); checkOutput("bubble_1", {30'd0, sk_bubble}, 32'd1);
        tick(); checkOutput("bubble_2", {30'd0, sk_bubble}, 32'd2);
        tick(); checkOutput("bubble_3", {30'd0, sk_bubble}, 32'd3);
        tick(); checkOutput("bubble_4", {30'd0, sk_bubble}, 32'd3);
        tick(); checkOutput("bubble_5", {30'd0, sk_bubble}, 32'd3);

        $display("[TB] streaming");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, i, 1'b1, 1'b0, 1'b0);
            tick();
            checkOutput("stream_valid", {31'd0, sk_out_valid}, 32'd1);
            checkOutput("stream_data", sk_out_data, i);
            checkOutput("stream_ctrl", {24'd0, sk_out_ctrl}, {24'd0, ~i[7:0]});
            checkOutput("stream_occ", {30'd0, sk_occ}, 32'd1);
            checkOutput("stream_ready", {31'd0, sk_in_ready}, 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("stream_end_valid", {31'd0, sk_out_valid}, 32'd0);
        checkOutput("stream_end_data", sk_out_data, 32'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_occ_a", {30'd0, sk_occ}, 32'd1);
        checkOutput("bp_ready_a", {31'd0, sk_in_ready}, 32'd1);
        applyStimulus(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_occ_b", {30'd0, sk_occ}, 32'd2);
        checkOutput("bp_ready_b", {31'd0, sk_in_ready}, 32'd0);
        checkOutput("bp_head_b", sk_out_data, 32'hA5);
        applyStimulus(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_occ_hold", {30'd0, sk_occ}, 32'd2);
        checkOutput("bp_head_hold", sk_out_data, 32'hA5);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bp_rel_data", sk_out_data, 32'h5A);
        checkOutput("bp_rel_ctrl", {24'd0, sk_out_ctrl}, 32'hA5);
        checkOutput("bp_rel_occ", {30'd0, sk_occ}, 32'd1);
        checkOutput("bp_rel_ready", {31'd0, sk_in_ready}, 32'd1);
        tick();
        checkOutput("bp_done_valid", {31'd0, sk_out_valid}, 32'd0);
        checkOutput("bp_done_occ", {30'd0, sk_occ}, 32'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h01, 1'b0, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 32'h02, 1'b0, 1'b0, 1'b0); tick();
        checkOutput("fl_pre_occ", {30'd0, sk_occ}, 32'd2);
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("fl_valid", {31'd0, sk_out_valid}, 32'd0);
        checkOutput("fl_occ", {30'd0, sk_occ}, 32'd0);
        checkOutput("fl_data", sk_out_data, 32'd0);
        checkOutput("fl_ctrl", {24'd0, sk_out_ctrl}, 32'd0);
        checkOutput("fl_ready", {31'd0, sk_in_ready}, 32'd1);
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("fl_one_occ", {30'd0, sk_occ}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("fl_after_valid", {31'd0, sk_out_valid}, 32'd0);
        checkOutput("fl_after_data", sk_out_data, 32'd0);

        $display("[TB] stall");
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0); tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("st_data_1", sk_out_data, 32'h11);
        checkOutput("st_occ_1", {30'd0, sk_occ}, 32'd1);
        tick();
        checkOutput("st_data_2", sk_out_data, 32'h11);
        checkOutput("st_occ_2", {30'd0, sk_occ}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("st_drain_valid", {31'd0, sk_out_valid}, 32'd0);
        applyStimulus(1'b1, 32'h66, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("st_acc_empty", sk_out_data, 32'h66);
        applyStimulus(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("st_acc_occ", {30'd0, sk_occ}, 32'd2);
        checkOutput("st_acc_head", sk_out_data, 32'h66);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("st_next_head", sk_out_data, 32'h77);
        tick();
        checkOutput("st_end_occ", {30'd0, sk_occ}, 32'd0);

        $display("[TB] mid-operation reset");
        applyStimulus(1'b1, 32'h88, 1'b0, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 32'h99, 1'b0, 1'b0, 1'b0); tick();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mr_occ", {30'd0, sk_occ}, 32'd0);
        checkOutput("mr_valid", {31'd0, sk_out_valid}, 32'd0);
        checkOutput("mr_bubble", {30'd0, sk_bubble}, 32'd0);
        checkOutput("mr_ready", {31'd0, sk_in_ready}, 32'd1);
        rst = 1'b0;
        applyStimulus(1'b1, 32'hAB, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mr_first_data", sk_out_data, 32'hAB);
        checkOutput("mr_first_occ", {30'd0, sk_occ}, 32'd1);
        checkOutput("mr_bubble_inc", {30'd0, sk_bubble}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();

        $display("[TB] single-entry stage");
        ns_in_valid = 1'b1; ns_in_data = 32'h101; ns_in_ctrl = 8'h01; ns_out_ready = 1'b1;
        #1 checkOutput("ns_ready_empty", {31'd0, ns_in_ready}, 32'd1);
        tick();
        checkOutput("ns_d1", ns_out_data, 32'h101);
        checkOutput("ns_occ_1", {30'd0, ns_occ}, 32'd1);
        ns_in_data = 32'h102; ns_in_ctrl = 8'h02; ns_out_ready = 1'b1;
        #1 checkOutput("ns_ready_drain", {31'd0, ns_in_ready}, 32'd1);
        tick();
        checkOutput("ns_d2", ns_out_data, 32'h102);
        checkOutput("ns_occ_2", {30'd0, ns_occ}, 32'd1);
        ns_in_data = 32'h103; ns_in_ctrl = 8'h03; ns_out_ready = 1'b0;
        #1 checkOutput("ns_ready_blocked", {31'd0, ns_in_ready}, 32'd0);
        tick();
        checkOutput("ns_d2_hold", ns_out_data, 32'h102);
        checkOutput("ns_occ_hold", {30'd0, ns_occ}, 32'd1);
        ns_out_ready = 1'b1;
        #1 checkOutput("ns_ready_again", {31'd0, ns_in_ready}, 32'd1);
        tick();
        checkOutput("ns_d3", ns_out_data, 32'h103);
        checkOutput("ns_c3", {24'd0, ns_out_ctrl}, 32'h03);
        ns_stall = 1'b1;
        #1 checkOutput("ns_ready_stall", {31'd0, ns_in_ready}, 32'd0);
        ns_stall = 1'b0; ns_in_valid = 1'b0;
        tick();
        checkOutput("ns_end_occ", {30'd0, ns_occ}, 32'd0);
        checkOutput("ns_end_data", ns_out_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
